// File: rtl/alu_share_arbiter_if.sv
// Bus bundle for alu_share_arbiter: request channel, shared ALU drive/return,
// response channel and busy. The arbiter uses the slave modport; the environment
// (requesters, ALU, response consumer) uses the master modport.
interface alu_share_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_operandA;
  logic [32*NUM_REQ-1:0] req_operandB;
  logic [5*NUM_REQ-1:0]  req_opcode;
  logic [5*NUM_REQ-1:0]  req_shiftamt;

  logic [31:0]           alu_operandA;
  logic [31:0]           alu_operandB;
  logic [4:0]            alu_opcode;
  logic [4:0]            alu_shiftamt;
  logic [31:0]           alu_result;
  logic                  alu_ne;
  logic                  alu_lt;
  logic                  alu_ovf;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [31:0]           resp_result;
  logic                  resp_ne;
  logic                  resp_lt;
  logic                  resp_ovf;
  logic                  busy;

  modport slave (
    input  req_valid, req_operandA, req_operandB, req_opcode, req_shiftamt,
    input  alu_result, alu_ne, alu_lt, alu_ovf, resp_ready,
    output req_ready, alu_operandA, alu_operandB, alu_opcode, alu_shiftamt,
    output resp_valid, resp_id, resp_result, resp_ne, resp_lt, resp_ovf, busy
  );

  modport master (
    output req_valid, req_operandA, req_operandB, req_opcode, req_shiftamt,
    output alu_result, alu_ne, alu_lt, alu_ovf, resp_ready,
    input  req_ready, alu_operandA, alu_operandB, alu_opcode, alu_shiftamt,
    input  resp_valid, resp_id, resp_result, resp_ne, resp_lt, resp_ovf, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU among NUM_REQ requesters. One operation
// in flight: IDLE (arbitrate/accept) -> EXEC (ALU settles) -> RESP (hold until
// consumed). Default arbitration is round-robin; defining ALU_SHARE_FIXED_PRIO_EN
// switches to fixed priority (lowest index wins).
module alu_share_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
) (
  input logic               clock,
  input logic               reset,
  alu_share_arbiter_if.slave bus_io
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        alu_a_q, alu_a_d;
  logic [31:0]        alu_b_q, alu_b_d;
  logic [4:0]         alu_op_q, alu_op_d;
  logic [4:0]         alu_sh_q, alu_sh_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [31:0]        res_q, res_d;
  logic               ne_q, ne_d;
  logic               lt_q, lt_d;
  logic               ovf_q, ovf_d;

  logic               grant_vld;
  logic [ID_W-1:0]    grant_idx;
  logic [NUM_REQ-1:0] req_ready_c;
  logic [31:0]        sel_a, sel_b;
  logic [4:0]         sel_op, sel_sh;

`ifdef ALU_SHARE_FIXED_PRIO_EN
  // Fixed priority: lowest-index valid requester wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus_io.req_valid[i]) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'(i);
      end
    end
  end
`else
  logic [ID_W-1:0]    last_grant_q, last_grant_d;
  int unsigned        rr_idx;
  logic [NUM_REQ-1:0] rr_shift;

  // Round-robin: first valid requester after the previous winner, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_idx    = 0;
    rr_shift  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      rr_idx = 32'(last_grant_q) + k;
      if (rr_idx >= NUM_REQ) rr_idx = rr_idx - NUM_REQ;
      rr_shift = bus_io.req_valid >> rr_idx;
      if (!grant_vld && rr_shift[0]) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'(rr_idx);
      end
    end
  end
`endif

  // Pick the winner's operand slice out of the flattened request buses.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    sel_sh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_a  = bus_io.req_operandA[32*i +: 32];
        sel_b  = bus_io.req_operandB[32*i +: 32];
        sel_op = bus_io.req_opcode[5*i +: 5];
        sel_sh = bus_io.req_shiftamt[5*i +: 5];
      end
    end
  end

  // Next-state and accept logic; registers hold unless the current state updates them.
  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    alu_sh_d    = alu_sh_q;
    id_d        = id_q;
    res_d       = res_q;
    ne_d        = ne_q;
    lt_d        = lt_q;
    ovf_d       = ovf_q;
    req_ready_c = '0;
`ifndef ALU_SHARE_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    unique case (state_q)
      StIdle: begin
        // No accept while reset is asserted: the operation would be dropped anyway.
        if (grant_vld && !reset) begin
          req_ready_c = NUM_REQ'(1) << grant_idx;
          alu_a_d     = sel_a;
          alu_b_d     = sel_b;
          alu_op_d    = sel_op;
          alu_sh_d    = sel_sh;
          id_d        = grant_idx;
`ifndef ALU_SHARE_FIXED_PRIO_EN
          last_grant_d = grant_idx;
`endif
          state_d     = StExec;
        end
      end
      StExec: begin
        res_d   = bus_io.alu_result;
        ne_d    = bus_io.alu_ne;
        lt_d    = bus_io.alu_lt;
        ovf_d   = bus_io.alu_ovf;
        state_d = StResp;
      end
      StResp: begin
        if (bus_io.resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      alu_sh_q <= '0;
      id_q     <= '0;
      res_q    <= '0;
      ne_q     <= 1'b0;
      lt_q     <= 1'b0;
      ovf_q    <= 1'b0;
`ifndef ALU_SHARE_FIXED_PRIO_EN
      last_grant_q <= ID_W'(NUM_REQ - 1);
`endif
    end else begin
      state_q  <= state_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      alu_sh_q <= alu_sh_d;
      id_q     <= id_d;
      res_q    <= res_d;
      ne_q     <= ne_d;
      lt_q     <= lt_d;
      ovf_q    <= ovf_d;
`ifndef ALU_SHARE_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign bus_io.req_ready    = req_ready_c;
  assign bus_io.alu_operandA = alu_a_q;
  assign bus_io.alu_operandB = alu_b_q;
  assign bus_io.alu_opcode   = alu_op_q;
  assign bus_io.alu_shiftamt = alu_sh_q;
  assign bus_io.resp_valid   = (state_q == StResp);
  assign bus_io.resp_id      = id_q;
  assign bus_io.resp_result  = res_q;
  assign bus_io.resp_ne      = ne_q;
  assign bus_io.resp_lt      = lt_q;
  assign bus_io.resp_ovf     = ovf_q;
  assign bus_io.busy         = (state_q != StIdle);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level reference model.
module tb_alu_share_arbiter;
  localparam int unsigned NumReq = 2;
  localparam int unsigned IdW    = 1;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    logic [4:0]  sh;
  } op_t;

  typedef struct packed {
    logic        ovf;
    logic        lt;
    logic        ne;
    logic [31:0] res;
  } alu_out_t;

  typedef struct packed {
    logic [31:0]    cyc;
    logic [IdW-1:0] id;
    logic [31:0]    res;
    logic           ne;
    logic           lt;
    logic           ovf;
  } resp_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] id;
  } grant_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  alu_share_arbiter_if #(.NUM_REQ(NumReq), .ID_W(IdW)) bus ();

  alu_share_arbiter #(.NUM_REQ(NumReq), .ID_W(IdW)) dut (
    .clock  (clock),
    .reset  (reset),
    .bus_io (bus)
  );

  // Behavioural ALU standing in for the external shared instance.
  function automatic alu_out_t alu_fn(logic [31:0] a, logic [31:0] b, logic [4:0] op,
                                      logic [4:0] sh);
    alu_out_t o;
    o.ne  = (a != b);
    o.lt  = ($signed(a) < $signed(b));
    o.ovf = 1'b0;
    case (op)
      5'd0: begin
        o.res = a + b;
        o.ovf = (a[31] == b[31]) && (o.res[31] != a[31]);
      end
      5'd1: begin
        o.res = a - b;
        o.ovf = (a[31] != b[31]) && (o.res[31] != a[31]);
      end
      5'd2:    o.res = a & b;
      5'd3:    o.res = a | b;
      5'd4:    o.res = a << sh;
      5'd5:    o.res = $signed(a) >>> sh;
      default: o.res = a ^ b;
    endcase
    return o;
  endfunction

  assign {bus.alu_ovf, bus.alu_lt, bus.alu_ne, bus.alu_result} =
      alu_fn(bus.alu_operandA, bus.alu_operandB, bus.alu_opcode, bus.alu_shiftamt);

  // Reference arbitration rule.
  function automatic int pick(logic [NumReq-1:0] mask, int last);
`ifdef ALU_SHARE_FIXED_PRIO_EN
    for (int i = 0; i < NumReq; i++) if (mask[i]) return i;
`else
    for (int k = 1; k <= NumReq; k++) begin
      int i;
      i = (last + k) % NumReq;
      if (mask[i]) return i;
    end
`endif
    return -1;
  endfunction

  int            n_checks = 0;
  int            n_errors = 0;
  int unsigned   cyc = 0;
  op_t           pend[NumReq][$];
  logic [NumReq-1:0] acc_seen = '0;
  logic [NumReq-1:0] drv_valid = '0;
  grant_t        grant_log[$];
  resp_t         resp_log[$];
  logic          rr_rand = 1'b0;
  logic          rr_fixed = 1'b1;

  function automatic op_t rand_op();
    op_t o;
    o.a  = $urandom;
    o.b  = $urandom;
    o.op = 5'($urandom_range(0, 31));
    o.sh = 5'($urandom_range(0, 31));
    return o;
  endfunction

  task automatic drive_reqs();
    op_t o;
    for (int i = 0; i < NumReq; i++) begin
      o = '0;
      if (pend[i].size() > 0) o = pend[i][0];
      bus.req_valid[i]              = (pend[i].size() > 0);
      bus.req_operandA[32*i +: 32]  = o.a;
      bus.req_operandB[32*i +: 32]  = o.b;
      bus.req_opcode[5*i +: 5]      = o.op;
      bus.req_shiftamt[5*i +: 5]    = o.sh;
    end
  endtask

  // One cycle: requesters retire accepted ops, inputs are driven after the
  // falling edge, and outputs are sampled 1 time unit later.
  task automatic step();
    resp_t r;
    grant_t g;
    @(negedge clock);
    for (int i = 0; i < NumReq; i++)
      if (acc_seen[i] && pend[i].size() > 0) void'(pend[i].pop_front());
    drive_reqs();
    bus.resp_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_fixed;
    #1;
    acc_seen  = bus.req_ready;
    drv_valid = bus.req_valid;
    for (int i = 0; i < NumReq; i++) begin
      if (bus.req_ready[i]) begin
        g.cyc = cyc;
        g.id  = i;
        grant_log.push_back(g);
      end
    end
    if (bus.resp_valid && bus.resp_ready) begin
      r.cyc = cyc;
      r.id  = bus.resp_id;
      r.res = bus.resp_result;
      r.ne  = bus.resp_ne;
      r.lt  = bus.resp_lt;
      r.ovf = bus.resp_ovf;
      resp_log.push_back(r);
    end
    cyc++;
  endtask

  task automatic do_reset();
    for (int i = 0; i < NumReq; i++) pend[i].delete();
    grant_log.delete();
    resp_log.delete();
    acc_seen = '0;
    rr_rand  = 1'b0;
    rr_fixed = 1'b1;
    reset    = 1'b1;
    step();
    step();
    reset    = 1'b0;
  endtask

  task automatic run_until_resps(int n, int budget);
    for (int c = 0; c < budget && resp_log.size() < n; c++) step();
  endtask

  task automatic test_reset();
    do_reset();
    step();
    n_checks++; if (bus.busy !== 1'b0) begin n_errors++;
      $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.resp_valid !== 1'b0) begin n_errors++;
      $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); end
    n_checks++; if (bus.req_ready !== '0) begin n_errors++;
      $display("FAIL reset_req_ready: got %b want 0", bus.req_ready); end
    n_checks++;
    if ({bus.alu_operandA, bus.alu_operandB, bus.alu_opcode, bus.alu_shiftamt} !== '0) begin
      n_errors++;
      $display("FAIL reset_alu: got a=%h b=%h op=%h sh=%h want all 0", bus.alu_operandA,
               bus.alu_operandB, bus.alu_opcode, bus.alu_shiftamt);
    end
    n_checks++;
    if ({bus.resp_result, bus.resp_id, bus.resp_ne, bus.resp_lt, bus.resp_ovf} !== '0) begin
      n_errors++;
      $display("FAIL reset_resp: got res=%h id=%0d flags=%b%b%b want all 0", bus.resp_result,
               bus.resp_id, bus.resp_ne, bus.resp_lt, bus.resp_ovf);
    end
  endtask

  task automatic test_single();
    op_t o;
    do_reset();
    o = '{a: 32'd7, b: 32'd5, op: 5'd0, sh: 5'd0};
    pend[0].push_back(o);
    run_until_resps(1, 20);
    n_checks++; if (resp_log.size() != 1 || grant_log.size() != 1) begin n_errors++;
      $display("FAIL single_count: got %0d grants %0d resps want 1/1", grant_log.size(),
               resp_log.size()); end
    else begin
      n_checks++; if (grant_log[0].id != 0) begin n_errors++;
        $display("FAIL single_grant: got %0d want 0", grant_log[0].id); end
      n_checks++; if (resp_log[0].cyc - grant_log[0].cyc != 2) begin n_errors++;
        $display("FAIL single_latency: got %0d want 2", resp_log[0].cyc - grant_log[0].cyc); end
      n_checks++; if (resp_log[0].res !== 32'd12 || resp_log[0].id !== 1'b0 ||
                      resp_log[0].ovf !== 1'b0) begin n_errors++;
        $display("FAIL single_resp: got res=%0d id=%0d ovf=%b want 12/0/0", resp_log[0].res,
                 resp_log[0].id, resp_log[0].ovf); end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    pend[0].push_back('{a: 32'd3, b: 32'd9, op: 5'd1, sh: 5'd0});
    pend[1].push_back('{a: 32'd1, b: 32'd0, op: 5'd4, sh: 5'd4});
    run_until_resps(2, 30);
    n_checks++; if (resp_log.size() != 2) begin n_errors++;
      $display("FAIL simul_count: got %0d resps want 2", resp_log.size()); end
    else begin
      n_checks++; if (grant_log[0].id != 0 || grant_log[1].id != 1) begin n_errors++;
        $display("FAIL simul_order: got %0d,%0d want 0,1", grant_log[0].id, grant_log[1].id); end
      n_checks++; if (resp_log[0].res !== 32'hFFFF_FFFA || resp_log[0].ne !== 1'b1 ||
                      resp_log[0].lt !== 1'b1 || resp_log[0].id !== 1'b0) begin n_errors++;
        $display("FAIL simul_first: got res=%h ne=%b lt=%b id=%0d want fffffffa/1/1/0",
                 resp_log[0].res, resp_log[0].ne, resp_log[0].lt, resp_log[0].id); end
      n_checks++; if (resp_log[1].res !== 32'd16 || resp_log[1].id !== 1'b1) begin n_errors++;
        $display("FAIL simul_second: got res=%0d id=%0d want 16/1", resp_log[1].res,
                 resp_log[1].id); end
      n_checks++; if (resp_log[1].cyc - resp_log[0].cyc != 3) begin n_errors++;
        $display("FAIL simul_spacing: got %0d want 3", resp_log[1].cyc - resp_log[0].cyc); end
    end
  endtask

  task automatic test_fairness();
    op_t ops[NumReq][6];
    int  used[NumReq];
    int  exp_g[6];
    alu_out_t exp_r[6];
    int  last;
    logic [NumReq-1:0] mask;
    do_reset();
    for (int i = 0; i < NumReq; i++) begin
      used[i] = 0;
      for (int k = 0; k < 6; k++) begin
        ops[i][k] = rand_op();
        pend[i].push_back(ops[i][k]);
      end
    end
    last = NumReq - 1;
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < NumReq; i++) mask[i] = (used[i] < 6);
      exp_g[n] = pick(mask, last);
      exp_r[n] = alu_fn(ops[exp_g[n]][used[exp_g[n]]].a, ops[exp_g[n]][used[exp_g[n]]].b,
                        ops[exp_g[n]][used[exp_g[n]]].op, ops[exp_g[n]][used[exp_g[n]]].sh);
      used[exp_g[n]]++;
      last = exp_g[n];
    end
    run_until_resps(6, 100);
    n_checks++; if (resp_log.size() < 6) begin n_errors++;
      $display("FAIL fair_timeout: got %0d resps want 6", resp_log.size()); end
    for (int n = 0; n < 6; n++) begin
      if (n < resp_log.size() && n < grant_log.size()) begin
        n_checks++; if (grant_log[n].id != exp_g[n] || resp_log[n].id != IdW'(exp_g[n])) begin
          n_errors++;
          $display("FAIL fair_grant[%0d]: got grant %0d id %0d want %0d", n, grant_log[n].id,
                   resp_log[n].id, exp_g[n]); end
        n_checks++; if ({resp_log[n].ovf, resp_log[n].lt, resp_log[n].ne, resp_log[n].res}
                        !== exp_r[n]) begin n_errors++;
          $display("FAIL fair_result[%0d]: got %h want %h", n, resp_log[n].res, exp_r[n].res); end
      end
    end
  endtask

  task automatic test_backpressure();
    op_t x, y;
    alu_out_t ex;
    do_reset();
    rr_fixed = 1'b0;
    x = rand_op();
    y = rand_op();
    ex = alu_fn(x.a, x.b, x.op, x.sh);
    pend[0].push_back(x);
    pend[1].push_back(y);
    for (int c = 0; c < 20 && !(bus.resp_valid === 1'b1); c++) step();
    n_checks++; if (bus.resp_valid !== 1'b1) begin n_errors++;
      $display("FAIL bp_timeout: resp_valid got %b want 1", bus.resp_valid); end
    for (int c = 0; c < 10; c++) begin
      step();
      n_checks++;
      if (bus.resp_valid !== 1'b1 || bus.busy !== 1'b1 || bus.req_ready !== '0 ||
          bus.resp_id !== 1'b0 || {bus.resp_ovf, bus.resp_lt, bus.resp_ne, bus.resp_result}
          !== ex || bus.alu_operandA !== x.a) begin
        n_errors++;
        $display("FAIL bp_hold[%0d]: got v=%b busy=%b rdy=%b id=%0d res=%h want 1/1/0/0/%h",
                 c, bus.resp_valid, bus.busy, bus.req_ready, bus.resp_id, bus.resp_result,
                 ex.res);
      end
    end
    rr_fixed = 1'b1;
    step();
    n_checks++; if (bus.req_ready !== 2'b00 || bus.resp_valid !== 1'b1) begin n_errors++;
      $display("FAIL bp_handshake: got rdy=%b v=%b want 00/1", bus.req_ready,
               bus.resp_valid); end
    step();
    n_checks++; if (bus.req_ready !== 2'b10) begin n_errors++;
      $display("FAIL bp_next_grant: got %b want 10", bus.req_ready); end
  endtask

  task automatic test_overflow();
    do_reset();
    pend[0].push_back('{a: 32'h7FFF_FFFF, b: 32'd1, op: 5'd0, sh: 5'd0});
    run_until_resps(1, 20);
    n_checks++; if (resp_log.size() != 1) begin n_errors++;
      $display("FAIL ovf_count: got %0d want 1", resp_log.size()); end
    else begin
      n_checks++; if (resp_log[0].res !== 32'h8000_0000 || resp_log[0].ovf !== 1'b1) begin
        n_errors++;
        $display("FAIL ovf_resp: got res=%h ovf=%b want 80000000/1", resp_log[0].res,
                 resp_log[0].ovf); end
    end
  endtask

  task automatic test_reset_exec();
    op_t dropped, o0, o1;
    do_reset();
    dropped = '{a: 32'd100, b: 32'd23, op: 5'd0, sh: 5'd0};
    o0      = '{a: 32'd40, b: 32'd2, op: 5'd0, sh: 5'd0};
    o1      = '{a: 32'd9, b: 32'd4, op: 5'd1, sh: 5'd0};
    pend[0].push_back(dropped);
    step();
    step();
    n_checks++; if (bus.busy !== 1'b1 || bus.alu_operandA !== dropped.a) begin n_errors++;
      $display("FAIL rexec_setup: got busy=%b a=%0d want 1/100", bus.busy,
               bus.alu_operandA); end
    reset = 1'b1;
    pend[0].push_back(o0);
    pend[1].push_back(o1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    step();
    n_checks++; if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) begin n_errors++;
      $display("FAIL rexec_state: got v=%b busy=%b want 0/0", bus.resp_valid, bus.busy); end
    n_checks++;
    if ({bus.alu_operandA, bus.alu_operandB, bus.alu_opcode, bus.alu_shiftamt} !== '0) begin
      n_errors++;
      $display("FAIL rexec_alu: got a=%h b=%h want 0", bus.alu_operandA, bus.alu_operandB);
    end
    n_checks++; if (bus.req_ready !== 2'b01) begin n_errors++;
      $display("FAIL rexec_grant: got %b want 01", bus.req_ready); end
    run_until_resps(2, 40);
    n_checks++; if (resp_log.size() != 2) begin n_errors++;
      $display("FAIL rexec_count: got %0d resps want 2", resp_log.size()); end
    else begin
      n_checks++; if (resp_log[0].id !== 1'b0 || resp_log[0].res !== 32'd42 ||
                      resp_log[1].id !== 1'b1 || resp_log[1].res !== 32'd5) begin n_errors++;
        $display("FAIL rexec_resps: got %0d:%0d %0d:%0d want 0:42 1:5", resp_log[0].id,
                 resp_log[0].res, resp_log[1].id, resp_log[1].res); end
    end
  endtask

  task automatic test_random();
    int m_phase, m_last, g;
    alu_out_t m_exp;
    logic [IdW-1:0] m_id;
    logic [31:0] m_a;
    logic [NumReq-1:0] exp_rdy;
    do_reset();
    rr_rand = 1'b1;
    m_phase = 0;
    m_last  = NumReq - 1;
    m_exp   = '0;
    m_id    = '0;
    m_a     = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NumReq; i++)
        if (pend[i].size() == 0 && $urandom_range(0, 3) == 0) pend[i].push_back(rand_op());
      step();
      exp_rdy = '0;
      g = -1;
      if (m_phase == 0 && drv_valid != '0) begin
        g = pick(drv_valid, m_last);
        exp_rdy[g] = 1'b1;
      end
      n_checks++; if (bus.req_ready !== exp_rdy || bus.busy !== (m_phase != 0) ||
                      bus.resp_valid !== (m_phase == 2)) begin n_errors++;
        $display("FAIL rand_ctrl[%0d]: got rdy=%b busy=%b v=%b want %b/%b/%b", c,
                 bus.req_ready, bus.busy, bus.resp_valid, exp_rdy, m_phase != 0,
                 m_phase == 2); end
      if (m_phase != 0) begin
        n_checks++; if (bus.alu_operandA !== m_a) begin n_errors++;
          $display("FAIL rand_alu_a[%0d]: got %h want %h", c, bus.alu_operandA, m_a); end
      end
      if (m_phase == 2) begin
        n_checks++; if (bus.resp_id !== m_id ||
                        {bus.resp_ovf, bus.resp_lt, bus.resp_ne, bus.resp_result} !== m_exp)
        begin n_errors++;
          $display("FAIL rand_resp[%0d]: got id=%0d res=%h want id=%0d res=%h", c,
                   bus.resp_id, bus.resp_result, m_id, m_exp.res); end
      end
      case (m_phase)
        0: if (g >= 0) begin
          m_exp   = alu_fn(pend[g][0].a, pend[g][0].b, pend[g][0].op, pend[g][0].sh);
          m_a     = pend[g][0].a;
          m_id    = IdW'(g);
          m_last  = g;
          m_phase = 1;
        end
        1: m_phase = 2;
        default: if (bus.resp_ready) m_phase = 0;
      endcase
    end
    rr_rand = 1'b0;
  endtask

  initial begin
    bus.req_valid    = '0;
    bus.req_operandA = '0;
    bus.req_operandB = '0;
    bus.req_opcode   = '0;
    bus.req_shiftamt = '0;
    bus.resp_ready   = 1'b1;
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_backpressure();
    test_overflow();
    test_reset_exec();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational `alu` instance among NUM_REQ requesters.
- Each requester presents an operation over a valid/ready handshake. The block picks one request round-robin, drives the shared ALU from registered operands, and captures the result and flags. It then returns them with the winning requester's ID over a valid/ready response channel.
- Sits between issue logic (or test drivers) and the shared ALU; the ALU instance lives outside this block.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ID_W, 1, width of the requester index (must equal clog2(NUM_REQ), minimum 1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept pulse; one-hot or zero.
- req_operandA  in  32*NUM_REQ  flattened operand A; requester i uses bits [32i+31:32i].
- req_operandB  in  32*NUM_REQ  flattened operand B.
- req_opcode  in  5*NUM_REQ  flattened ALU opcode.
- req_shiftamt  in  5*NUM_REQ  flattened shift amount.
- alu_operandA  out  32  to shared ALU data_operandA.
- alu_operandB  out  32  to shared ALU data_operandB.
- alu_opcode  out  5  to shared ALU ctrl_ALUopcode.
- alu_shiftamt  out  5  to shared ALU ctrl_shiftamt.
- alu_result  in  32  from ALU data_result.
- alu_ne  in  1  from ALU isNotEqual.
- alu_lt  in  1  from ALU isLessThan.
- alu_ovf  in  1  from ALU overflow.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumer ready.
- resp_id  out  ID_W  index of the requester that issued the operation.
- resp_result  out  32  captured ALU result.
- resp_ne  out  1  captured isNotEqual.
- resp_lt  out  1  captured isLessThan.
- resp_ovf  out  1  captured overflow.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Interface: one clock `clock`; reset `reset` is synchronous, active-high.
- States: IDLE, EXEC, RESP; 2-bit state register.
- Reset (sampled high at a rising edge) does all of the following, from any state including mid-operation:
  - state goes to IDLE and any in-flight operation is dropped, with no response.
  - req_ready=0, resp_valid=0, busy=0.
  - All alu_* registers = 0 (opcode 0 = add, so the ALU sees 0+0).
  - resp_* registers = 0.
  - Round-robin pointer last_grant = NUM_REQ-1, so requester 0 wins first.
- IDLE: if any req_valid bit is set, select the winner g:
  - Round-robin: g is the first set bit scanning last_grant+1, last_grant+2, ... modulo NUM_REQ.
  - req_ready[g] is asserted combinationally in this cycle only.
  - At the clock edge: latch requester g's operandA/operandB/opcode/shiftamt into the alu_* registers, latch g into the ID register, set last_grant=g, go to EXEC.
  - With no valid requests, stay in IDLE with req_ready=0.
- EXEC (exactly 1 cycle):
  - alu_* hold stable.
  - At the clock edge, capture alu_result/ne/lt/ovf into the resp_* registers, set resp_valid=1, go to RESP.
- RESP:
  - resp_valid=1; resp_* and alu_* held stable.
  - When resp_valid and resp_ready are both high at an edge: resp_valid goes to 0 and state goes to IDLE.
  - Backpressure is unbounded; the block holds RESP indefinitely.
- Latency: the accept edge is cycle 0; resp_valid is high from cycle 2.
- Throughput: with resp_ready tied high, one operation per 3 cycles.
- Requests are sampled only in IDLE. Requests raised during EXEC/RESP wait; a request arriving in the same cycle as the response handshake is not accepted until the next IDLE cycle.
- Requester protocol: hold valid and operands stable until req_ready. The arbiter never depends on a requester dropping valid.
- All flags are passed through raw; interpretation (ne/lt for opcode 1, ovf for opcodes 0/1) belongs to the consumer.
- Opcodes are not checked; any 5-bit value is forwarded.
- Only one operation is ever in flight.

Optional Feature:
- Macro: ALU_SHARE_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-index valid requester always wins, and last_grant is unused (its reset value is irrelevant).
- Undefined (default): round-robin as specified above.

Test Plan:
- Single request, requester 0:
  - Stimulus: A=7, B=5, opcode 0, shiftamt 0.
  - Required: req_ready[0] pulse at cycle 0; resp_valid at cycle 2 with result=12, id=0, ovf=0.
- Simultaneous requests, both held valid, resp_ready=1:
  - Stimulus: requester 0 issues 3-9 (opcode 1); requester 1 issues 1<<4 (opcode 4, shamt 4).
  - Required: grant order 0 then 1.
  - First response: result=-6, ne=1, lt=1.
  - Second response: result=16, id=1, exactly 3 cycles after the first.
- Round-robin fairness:
  - Stimulus: both requesters continuously valid for 6 operations.
  - Required: grant sequence 0,1,0,1,0,1.
  - With ALU_SHARE_FIXED_PRIO_EN defined: sequence 0,0,0,0,0,0.
- Backpressure:
  - Stimulus: resp_ready=0 for 10 cycles after resp_valid rises, with requester 1 valid throughout.
  - Required: resp_* stable, no req_ready pulse, busy=1; after resp_ready rises, requester 1 is granted on the first IDLE cycle.
- Overflow:
  - Stimulus: A=0x7FFFFFFF, B=1, opcode 0.
  - Required: resp_result=0x80000000, resp_ovf=1.
- Reset during EXEC:
  - Stimulus: assert reset for 1 cycle.
  - Required: next cycle resp_valid=0, busy=0, alu_*=0, and no response is ever produced for the dropped operation; the next grant goes to requester 0.
